// File: rtl/serial_addsub_pkg.sv
// rtl/serial_addsub_pkg.sv - shared constants and helpers for the bit-serial adder/subtractor
// Contents:
//   state_t      FSM state type (1 bit)
//   STATE_IDLE   waiting for start
//   STATE_RUN    shifting operands through the full-adder cell
//   W_MIN/W_MAX  legal operand width range
//   cnt_width()  width of the bit counter for a given operand width
package serial_addsub_pkg;

  typedef logic state_t;

  localparam state_t STATE_IDLE = 1'b0;
  localparam state_t STATE_RUN  = 1'b1;

  localparam int W_MIN = 2;
  localparam int W_MAX = 32;

  // Counter must be able to hold W itself, hence w+1.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/serial_addsub_fa_cell.sv
// rtl/serial_addsub_fa_cell.sv - single gate-level full-adder cell
// Ports:
//   x, y  in   operand bits
//   cin   in   carry in
//   s     out  sum bit
//   cout  out  carry out
module fa_cell (
  input  logic x,
  input  logic y,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic xy_x;

  assign xy_x = x ^ y;
  assign s    = xy_x ^ cin;
  assign cout = (x & y) | (xy_x & cin);

endmodule

// File: rtl/serial_addsub.sv
// rtl/serial_addsub.sv - bit-serial W-bit adder/subtractor with start/busy/done handshake
// Ports:
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low reset
//   start     in   request, sampled only while busy=0
//   sub       in   0: a+b, 1: a-b; sampled with start
//   a, b      in   W-bit operands; sampled with start
//   busy      out  operation in progress
//   done      out  one-cycle pulse, result valid from this cycle
//   sum       out  W-bit result, held until the next accepted start
//   cout      out  carry out of the MSB (subtract: 1 = no borrow)
//   overflow  out  signed overflow
module serial_addsub
  import serial_addsub_pkg::*;
#(
  parameter int W     = 8,
  parameter int CNT_W = cnt_width(W)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         sub,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         overflow
);

  if (W < W_MIN || W > W_MAX) begin : g_w_range
    $error("serial_addsub: W out of range");
  end

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [W-1:0]     a_sr;
  logic [W-1:0]     b_sr;
  logic             carry;
  logic             fa_s;
  logic             fa_c;
  logic             last_bit;

  fa_cell u_fa (
    .x    (a_sr[0]),
    .y    (b_sr[0]),
    .cin  (carry),
    .s    (fa_s),
    .cout (fa_c)
  );

  assign busy     = (state == STATE_RUN);
  assign last_bit = (cnt == CNT_W'(W - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= STATE_IDLE;
      cnt      <= '0;
      a_sr     <= '0;
      b_sr     <= '0;
      carry    <= 1'b0;
      sum      <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        STATE_IDLE: begin
          if (start) begin
            // Subtraction is a + ~b + 1: the +1 enters as the initial carry.
            a_sr  <= a;
            b_sr  <= sub ? ~b : b;
            carry <= sub;
            cnt   <= '0;
            sum   <= '0;
            state <= STATE_RUN;
          end
        end
        default: begin
          // Result bits enter at the MSB so the LSB-first stream lands in place after W shifts.
          sum   <= {fa_s, sum[W-1:1]};
          a_sr  <= {1'b0, a_sr[W-1:1]};
          b_sr  <= {1'b0, b_sr[W-1:1]};
          carry <= fa_c;
          cnt   <= cnt + CNT_W'(1);
          if (last_bit) begin
            // carry still holds the carry into the MSB on this edge.
            cout     <= fa_c;
            overflow <= fa_c ^ carry;
            done     <= 1'b1;
            state    <= STATE_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_addsub.sv
// tb/tb_serial_addsub.sv - self-checking bench for serial_addsub (W=8)
module tb_serial_addsub;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         start = 1'b0;
  logic         sub = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         overflow;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  serial_addsub #(.W(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .sub      (sub),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .sum      (sum),
    .cout     (cout),
    .overflow (overflow)
  );

  // Golden model from integer arithmetic: unsigned range gives carry, signed range gives overflow.
  function automatic exp_t golden(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
    exp_t e;
    int   ux, uy, sx, sy, r;
    ux = int'(x);
    uy = int'(y);
    sx = int'($signed(x));
    sy = int'($signed(y));
    if (s) begin
      e.sum  = W'(ux - uy);
      e.cout = (ux >= uy);
      r      = sx - sy;
    end else begin
      e.sum  = W'(ux + uy);
      e.cout = ((ux + uy) >= (1 << W));
      r      = sx + sy;
    end
    e.ovf = (r > ((1 << (W - 1)) - 1)) || (r < -(1 << (W - 1)));
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic compare_out(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s.sb_underflow observed=done expected=no_done", tag);
    end else begin
      e = sb.pop_front();
      check({tag, ".sum"}, 32'(sum), 32'(e.sum));
      check({tag, ".cout"}, 32'(cout), 32'(e.cout));
      check({tag, ".ovf"}, 32'(overflow), 32'(e.ovf));
    end
  endtask

  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic s, input string tag);
    int lat;
    sb.push_back(golden(x, y, s));
    a = x;
    b = y;
    sub = s;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({tag, ".busy"}, 32'(busy), 32'd1);
    check({tag, ".sum_clr"}, 32'(sum), 32'd0);
    lat = 0;
    while (!done && lat < 4 * W) begin
      @(negedge clk);
      lat++;
    end
    check({tag, ".lat"}, 32'(lat), 32'(W));
    compare_out(tag);
    @(negedge clk);
    check({tag, ".done_pulse"}, 32'(done), 32'd0);
    check({tag, ".idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int ndone;
    int nops;
    int cyc;
    int last;

    #1 rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.done", 32'(done), 32'd0);
    check("rst.sum", 32'(sum), 32'd0);
    check("rst.cout", 32'(cout), 32'd0);
    check("rst.ovf", 32'(overflow), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(8'h3C, 8'h15, 1'b0, "add_3c_15");
    run_op(8'hFF, 8'h01, 1'b0, "add_ff_01");
    run_op(8'h7F, 8'h01, 1'b0, "add_7f_01");
    run_op(8'h10, 8'h20, 1'b1, "sub_10_20");
    run_op(8'h80, 8'h01, 1'b1, "sub_80_01");
    run_op(8'h55, 8'h55, 1'b1, "sub_55_55");

    // Starts during a busy op must be ignored.
    sb.push_back(golden(8'h12, 8'h34, 1'b0));
    a = 8'h12;
    b = 8'h34;
    sub = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ndone = 0;
    for (int c = 1; c <= 3 * W; c++) begin
      if (c == 3 || c == 5) begin
        start = 1'b1;
        a = 8'hFF;
        b = 8'hFF;
        sub = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      if (done) begin
        ndone++;
        if (ndone == 1) check("busy_start.lat", 32'(c), 32'(W));
        compare_out("busy_start");
      end
    end
    start = 1'b0;
    check("busy_start.ndone", 32'(ndone), 32'd1);
    check("busy_start.idle", 32'(busy), 32'd0);

    // Reset mid-operation aborts with no done pulse.
    run_op(8'h7F, 8'h01, 1'b0, "pre_abort");
    a = 8'hA5;
    b = 8'h5A;
    sub = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort.busy", 32'(busy), 32'd0);
    check("abort.done", 32'(done), 32'd0);
    check("abort.sum", 32'(sum), 32'd0);
    check("abort.cout", 32'(cout), 32'd0);
    check("abort.ovf", 32'(overflow), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int c = 0; c < 3 * W; c++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("abort.ndone", 32'(ndone), 32'd0);

    // Start held high: a new op is accepted in each done cycle.
    start = 1'b1;
    ndone = 0;
    nops = 0;
    cyc = 0;
    last = -1;
    while (ndone < 1000 && cyc < 1000 * (W + 1) + 50) begin
      if (done) begin
        compare_out("stream");
        if (last >= 0) check("stream.interval", 32'(cyc - last), 32'(W + 1));
        last = cyc;
        ndone++;
      end
      if (!busy) begin
        if (nops < 1000) begin
          a = W'($urandom);
          b = W'($urandom);
          sub = 1'($urandom);
          sb.push_back(golden(a, b, sub));
          nops++;
        end else begin
          start = 1'b0;
        end
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    check("stream.ndone", 32'(ndone), 32'd1000);
    check("stream.sb_empty", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
